// File: rtl/xor_parity_accumulator_pkg.sv
// Shared types and helpers for the XOR parity library: frame state and channel slicing.
package xor_lib_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // LSB position of channel c inside a packed CHANNELS*WIDTH bus.
    function automatic int lane_lsb(input int c, input int width);
        return c * width;
    endfunction

endpackage

// File: rtl/xor_parity_accumulator_lane.sv
// One XOR channel: WIDTH-bit A^B, its reduction parity and the running frame parity bit.
module xor_lane
    import xor_lib_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             start,
    input  logic             step,
    output logic [WIDTH-1:0] x,
    output logic             acc_next
);

    logic acc;
    logic r;

    // A starting beat seeds from Mode instead of the previous accumulator value.
    always_comb begin
        x        = a ^ b;
        r        = ^x;
        acc_next = (start ? mode : acc) ^ r;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/xor_parity_accumulator.sv
// Registered multi-channel XOR with framed per-channel parity and a one-deep result slot.
module xor_parity_accumulator
    import xor_lib_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int          Delay    = 0
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        In_valid,
    output logic                        In_ready,
    input  logic [CHANNELS*WIDTH-1:0]   A,
    input  logic [CHANNELS*WIDTH-1:0]   B,
    input  logic                        Sof,
    input  logic                        Eof,
    input  logic                        Mode,
    output logic [CHANNELS*WIDTH-1:0]   Y,
    output logic                        Y_valid,
    output logic [CHANNELS-1:0]         Parity,
    output logic                        Parity_valid,
    input  logic                        Parity_ready,
    output logic                        Frame_err
);

    state_t                      state;
    logic                        accept;
    logic                        start;
    logic                        restart;
    logic [CHANNELS*WIDTH-1:0]   x;
    logic [CHANNELS-1:0]         fin;

    // Delay only matters to behavioural models of the original part; outputs here are undelayed.
    if (Delay != 0) begin : g_sim_delay
    end

    always_comb begin
        In_ready = !Parity_valid || Parity_ready;
        accept   = In_valid && In_ready;
        start    = accept && ((state == IDLE) || Sof);
        restart  = accept && (state == ACCUM) && Sof;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        xor_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk      (Clk),
            .reset_n  (Reset_n),
            .a        (A[lane_lsb(c, WIDTH) +: WIDTH]),
            .b        (B[lane_lsb(c, WIDTH) +: WIDTH]),
            .mode     (Mode),
            .start    (start),
            .step     (accept),
            .x        (x[lane_lsb(c, WIDTH) +: WIDTH]),
            .acc_next (fin[c])
        );
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            Y            <= '0;
            Y_valid      <= 1'b0;
            Parity       <= '0;
            Parity_valid <= 1'b0;
            Frame_err    <= 1'b0;
        end else begin
            Y_valid   <= accept;
            Frame_err <= restart;
            if (accept) begin
                Y     <= x;
                state <= Eof ? IDLE : ACCUM;
            end
            // A new Eof refills the slot in the same cycle it is drained.
            if (accept && Eof) begin
                Parity       <= fin;
                Parity_valid <= 1'b1;
            end else if (Parity_valid && Parity_ready) begin
                Parity_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Randomized and directed checks of xor_parity_accumulator against a frame-level parity model.
module tb_xor_parity_accumulator;

    localparam int W  = 8;
    localparam int CH = 4;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              In_valid, Sof, Eof, Mode, Parity_ready;
    logic [CH*W-1:0]   A, B;
    logic              In_ready, Y_valid, Parity_valid, Frame_err;
    logic [CH*W-1:0]   Y;
    logic [CH-1:0]     Parity;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit              m_in_frame;
    bit [CH-1:0]     m_acc;
    bit [CH*W-1:0]   m_y;
    bit              m_yv, m_pv, m_ferr;
    bit [CH-1:0]     m_par;

    always #5 Clk = ~Clk;

    xor_parity_accumulator #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .Delay    (0)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .A            (A),
        .B            (B),
        .Sof          (Sof),
        .Eof          (Eof),
        .Mode         (Mode),
        .Y            (Y),
        .Y_valid      (Y_valid),
        .Parity       (Parity),
        .Parity_valid (Parity_valid),
        .Parity_ready (Parity_ready),
        .Frame_err    (Frame_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic bit [CH-1:0] beat_parity(input bit [CH*W-1:0] a, input bit [CH*W-1:0] b);
        bit [CH*W-1:0] d;
        bit [CH-1:0]   p;
        d = a ^ b;
        for (int c = 0; c < CH; c++) begin
            p[c] = ($countones((d >> (c * W)) & {W{1'b1}}) % 2) == 1;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_acc = '0; m_y = '0; m_yv = 0; m_pv = 0; m_ferr = 0; m_par = '0;
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, "_y"},      Y,            m_y);
        check_eq({pfx, "_yv"},     Y_valid,      m_yv);
        check_eq({pfx, "_par"},    Parity,       m_par);
        check_eq({pfx, "_pv"},     Parity_valid, m_pv);
        check_eq({pfx, "_ferr"},   Frame_err,    m_ferr);
    endtask

    // One clock cycle: drive, check ready, clock, update model, check registered outputs.
    task automatic cycle(input bit v, input bit sof, input bit eof, input bit mode, input bit pr,
                         input bit [CH*W-1:0] a, input bit [CH*W-1:0] b);
        bit          rdy;
        bit [CH-1:0] base, nacc;
        In_valid = v; Sof = sof; Eof = eof; Mode = mode; Parity_ready = pr; A = a; B = b;
        #1;
        rdy = !m_pv || pr;
        check_eq("in_ready", In_ready, rdy);
        @(posedge Clk);
        m_ferr = 0;
        m_yv   = 0;
        if (m_pv && pr) m_pv = 0;
        if (v && rdy) begin
            m_yv = 1;
            m_y  = a ^ b;
            if (m_in_frame && sof) m_ferr = 1;
            base = (!m_in_frame || sof) ? (mode ? '1 : '0) : m_acc;
            nacc = base ^ beat_parity(a, b);
            m_acc = nacc;
            if (eof) begin
                m_par = nacc; m_pv = 1; m_in_frame = 0;
            end else begin
                m_in_frame = 1;
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    initial begin
        bit [CH-1:0] held;
        Reset_n = 0; In_valid = 0; Sof = 0; Eof = 0; Mode = 0; Parity_ready = 0; A = '0; B = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("rst");
        check_eq("rst_in_ready", In_ready, 1);
        Reset_n = 1;

        // Reset in the middle of a frame drops it without Frame_err
        cycle(1, 1, 0, 0, 1, 32'h1234_5678, 32'h0F0F_0F0F);
        Reset_n = 0; In_valid = 1; Sof = 0; Eof = 0;
        repeat (2) @(posedge Clk);
        model_reset();
        #1;
        check_outputs("midrst");
        check_eq("midrst_in_ready", In_ready, 1);
        Reset_n = 1;
        cycle(1, 0, 1, 0, 1, 32'h0000_0007, 32'h0000_0000);
        check_eq("after_rst_ferr", Frame_err, 0);
        check_eq("after_rst_par0", Parity[0], 1);

        // Even 2-beat frame
        cycle(1, 1, 0, 0, 1, 32'h0000_000F, 32'h0000_0001);
        check_eq("even_y0_b1", Y[7:0], 8'h0E);
        cycle(1, 0, 1, 0, 1, 32'h0000_00FF, 32'h0000_0000);
        check_eq("even_y0_b2", Y[7:0], 8'hFF);
        check_eq("even_par0", Parity[0], 1);
        check_eq("even_pv", Parity_valid, 1);

        // Odd frame; Mode dropping on beat 2 is ignored
        cycle(1, 1, 0, 1, 1, 32'h0000_000F, 32'h0000_0001);
        cycle(1, 0, 1, 0, 1, 32'h0000_00FF, 32'h0000_0000);
        check_eq("odd_par0", Parity[0], 0);

        // Backpressure: slot held, input stalled
        held = Parity;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 1, 0, 0, 32'h0000_0001, 32'h0000_0000);
            check_eq("bp_in_ready", In_ready, 0);
            check_eq("bp_par_stable", Parity, held);
        end
        cycle(1, 1, 1, 0, 1, 32'h0000_0001, 32'h0000_0000);
        check_eq("bp_resume_par0", Parity[0], 1);
        check_eq("bp_resume_pv", Parity_valid, 1);

        // Restart inside a frame
        cycle(1, 1, 0, 0, 1, 32'h0000_0001, 32'h0000_0000);
        cycle(1, 0, 0, 0, 1, 32'h0000_0055, 32'h0000_0000);
        check_eq("rs_no_ferr", Frame_err, 0);
        cycle(1, 1, 0, 0, 1, 32'h0000_0003, 32'h0000_0000);
        check_eq("rs_ferr", Frame_err, 1);
        cycle(1, 0, 1, 0, 1, 32'h0000_0000, 32'h0000_0000);
        check_eq("rs_ferr_once", Frame_err, 0);
        check_eq("rs_par0", Parity[0], 0);

        // Full throughput single-beat frames
        for (int i = 0; i < 16; i++) begin
            bit [CH*W-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            cycle(1, 1, 1, 0, 1, ra, rb);
            check_eq("tput_pv", Parity_valid, 1);
            check_eq("tput_par", Parity, beat_parity(ra, rb));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                  $urandom % 2, ($urandom % 4) != 0, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_parity_accumulator.md
# xor_parity_accumulator

Parametrised, registered successor to the quad 2-input XOR gate in the 74LSXX library. It computes CHANNELS independent WIDTH-bit XORs (A^B) per accepted beat. It also accumulates a per-channel running parity over framed bursts (Sof/Eof) and presents the final frame parity through a one-deep valid/ready output slot. Used as a parity generator/checker front end for the lab datapaths.

## Interface
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of independent XOR channels
- Delay, 0, simulation-only output delay in ns applied to all outputs (#Delay); 0 for synthesis
- Clk  input  1  rising-edge clock
- Reset_n  input  1  synchronous, active-low reset (sampled on Clk rising edge)
- In_valid  input  1  beat present on A/B/Sof/Eof
- In_ready  output  1  block can accept a beat this cycle
- A  input  CHANNELS*WIDTH  operand A; channel c occupies bits [c*WIDTH +: WIDTH]
- B  input  CHANNELS*WIDTH  operand B, same packing
- Sof  input  1  first beat of frame
- Eof  input  1  last beat of frame (Sof&&Eof = single-beat frame)
- Mode  input  1  0 = even parity (accumulator seeds 0), 1 = odd parity (seeds 1); sampled on the Sof beat
- Y  output  CHANNELS*WIDTH  registered A^B of last accepted beat
- Y_valid  output  1  one-cycle pulse, Y updated
- Parity  output  CHANNELS  final per-channel frame parity
- Parity_valid  output  1  Parity holds a completed frame result
- Parity_ready  input  1  consumer takes Parity
- Frame_err  output  1  one-cycle pulse: frame restarted (Sof while in ACCUM)

## Operation
- Accept = In_valid && In_ready. In_ready = !Parity_valid || Parity_ready (combinational, no other dependency).
- Per accepted beat: Y <= A^B (all channels); r[c] = ^(A_c ^ B_c).
- States IDLE, ACCUM; per-channel accumulator acc[c].
- IDLE + accept: any beat starts a frame (Sof implied). acc[c] <= Mode ^ r[c]. Eof also set -> result to Parity slot, stay IDLE; else -> ACCUM.
- ACCUM + accept, no Sof: acc[c] <= acc[c] ^ r[c]. Eof -> Parity[c] <= acc[c] ^ r[c], Parity_valid <= 1, -> IDLE.
- ACCUM + accept with Sof: Frame_err pulses; old frame discarded; reseed as in IDLE (Eof handled likewise).
- Parity slot: Parity_valid clears on Parity_valid && Parity_ready unless a new Eof is accepted that cycle (stays 1, Parity takes new value).
- Non-accepted cycles: no state, acc or Y change.

## Timing
- Reset (Reset_n=0 at edge): state IDLE, acc=0, Y=0, Y_valid=0, Parity=0, Parity_valid=0, Frame_err=0; In_ready therefore 1 in the following cycle. Reset mid-frame drops the frame silently (no Frame_err).
- Latency: accepted beat at edge n -> Y/Y_valid valid after edge n (1 cycle). Eof beat at edge n -> Parity_valid high after edge n.
- Parity and Parity_valid hold stable while Parity_valid && !Parity_ready; In_ready low in that case; In_valid may stay asserted.
- Full throughput: back-to-back single-beat frames with Parity_ready held 1 accept every cycle.
- Mode changes mid-frame are ignored.

## Structure
- Shared package xor_lib_pkg: state enum (IDLE, ACCUM), channel slice macro/function for [c*WIDTH +: WIDTH].
- Sub-module xor_lane (one channel: WIDTH-bit XOR, reduction parity, accumulator bit), instantiated CHANNELS times via generate; FSM and handshake in the top.

## Test plan
- Reset: hold Reset_n=0 two cycles mid-frame -> all outputs 0, In_ready=1, next beat treated as new frame, no Frame_err.
- Even 2-beat frame, ch0: A=8'h0F,B=8'h01 (Sof, Mode=0) then A=8'hFF,B=8'h00 (Eof) -> Y ch0 = 8'h0E then 8'hFF; Parity[0]=1 one cycle after Eof beat.
- Same stimulus with Mode=1 -> Parity[0]=0; Mode toggled to 0 on beat 2 has no effect.
- Backpressure: Parity_ready=0, Parity_valid=1 -> In_ready=0, Parity stable 5 cycles; Parity_ready=1 -> accept resumes same cycle, next Eof replaces Parity without a gap.
- Restart: Sof, mid, Sof(A=8'h03,B=8'h00,Mode=0), Eof(A=B=8'h00) -> Frame_err single pulse on 3rd beat; Parity[0]=0.
- Throughput: 16 consecutive Sof&&Eof beats, random A/B, Parity_ready=1 -> Parity_valid high 16 cycles, each Parity[c] = ^(A_c^B_c) of the matching beat.
